k12a_clock_ctrl: RTL and testbench

- Synthesizable clock/reset controller for the k12a core; generalizes bench-style clock and reset control into on-chip hardware.
- Sits between board clock/reset/buttons and the k12a core.
- Produces a stretched, synchronously-released core reset and a clock-enable that gates core advancement.
- Modes: halt, free-run, single-step, programmable divided run.

---
 rtl/k12a_clock_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_k12a_clock_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/k12a_clock_ctrl.sv
// k12a_clock_ctrl: clock/reset controller for the k12a core.
// Stretches and synchronously releases the core reset, and drives a registered
// clock-enable in halt, free-run, single-step or divided-run mode.
// Optional breakpoint support is enabled by defining K12A_CLOCK_CTRL_BREAK_EN.
module k12a_clock_ctrl #(
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned DIV_WIDTH       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned COUNT_WIDTH     = 32
) (
    input  logic                   sys_clock,
    input  logic                   reset_n,
    input  logic [1:0]             mode,
    input  logic [DIV_WIDTH-1:0]   divisor,
    input  logic                   step_button,
`ifdef K12A_CLOCK_CTRL_BREAK_EN
    input  logic [15:0]            pc,
    input  logic [15:0]            break_addr,
    input  logic                   break_valid,
    output logic                   halted,
`endif
    output logic                   cpu_reset_n,
    output logic                   clock_en,
    output logic                   running,
    output logic [COUNT_WIDTH-1:0] cycle_count
);

    localparam int unsigned RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned DB_CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_FREE = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_DIV  = 2'b11;

    typedef enum logic {
        ST_RESET  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             rst_sync_q, rst_sync_d;
    logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic                   cpu_reset_n_q, cpu_reset_n_d;
    logic                   clock_en_q, clock_en_d;
    logic [COUNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic [1:0]             mode_prev_q, mode_prev_d;
    logic [1:0]             step_sync_q, step_sync_d;
    logic [DB_CNT_W-1:0]    db_cnt_q, db_cnt_d;
    logic                   db_level_q, db_level_d;
`ifdef K12A_CLOCK_CTRL_BREAK_EN
    logic                   halted_q, halted_d;
`endif

    logic step_pulse;
    logic mode_changed;

    // Next-state logic for reset stretch, debouncer, divider and clock-enable
    always_comb begin
        state_d       = state_q;
        rst_sync_d    = {rst_sync_q[0], 1'b1};
        rst_cnt_d     = rst_cnt_q;
        cpu_reset_n_d = cpu_reset_n_q;
        clock_en_d    = 1'b0;
        cycle_count_d = cycle_count_q + COUNT_WIDTH'(clock_en_q);
        div_cnt_d     = div_cnt_q;
        mode_prev_d   = mode;
        step_sync_d   = {step_sync_q[0], step_button};
        db_cnt_d      = db_cnt_q;
        db_level_d    = db_level_q;
        step_pulse    = 1'b0;
        mode_changed  = (mode != mode_prev_q);
`ifdef K12A_CLOCK_CTRL_BREAK_EN
        halted_d      = halted_q;
`endif

        // Debounce: the synced level must differ from the accepted level for
        // DEBOUNCE_CYCLES consecutive cycles before it is taken.
        if (step_sync_q[1] != db_level_q) begin
            if (db_cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_level_d = step_sync_q[1];
                db_cnt_d   = '0;
                step_pulse = step_sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + DB_CNT_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end

        if (mode_changed) begin
            div_cnt_d = '0;
        end

        if (state_q == ST_RESET) begin
            // Hold the core in reset until the synchronized release has been
            // seen for RESET_CYCLES cycles.
            if (rst_sync_q[1]) begin
                if (rst_cnt_q == RST_CNT_W'(RESET_CYCLES - 1)) begin
                    state_d       = ST_ACTIVE;
                    cpu_reset_n_d = 1'b1;
                    rst_cnt_d     = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end
        end else begin
            if (!mode_changed) begin
                case (mode)
                    MODE_HALT: clock_en_d = 1'b0;
                    MODE_FREE: clock_en_d = 1'b1;
                    MODE_STEP: clock_en_d = step_pulse;
                    MODE_DIV: begin
                        // >= so that lowering the divisor below the count
                        // still fires and wraps on the next compare.
                        if (div_cnt_q >= divisor) begin
                            clock_en_d = 1'b1;
                            div_cnt_d  = '0;
                        end else begin
                            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                        end
                    end
                endcase
            end
`ifdef K12A_CLOCK_CTRL_BREAK_EN
            // A hit suppresses the enable on the same edge so the core stops
            // right after executing the breakpoint address.
            if (halted_q) begin
                clock_en_d = step_pulse && !mode_changed;
                if (mode_changed || step_pulse) begin
                    halted_d = 1'b0;
                end
            end else if (clock_en_q && break_valid && (pc == break_addr)) begin
                halted_d   = 1'b1;
                clock_en_d = 1'b0;
            end
`endif
        end
    end

    // State and output registers, all cleared by the asynchronous reset
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RESET;
            rst_sync_q    <= '0;
            rst_cnt_q     <= '0;
            cpu_reset_n_q <= 1'b0;
            clock_en_q    <= 1'b0;
            cycle_count_q <= '0;
            div_cnt_q     <= '0;
            mode_prev_q   <= '0;
            step_sync_q   <= '0;
            db_cnt_q      <= '0;
            db_level_q    <= 1'b0;
`ifdef K12A_CLOCK_CTRL_BREAK_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rst_sync_q    <= rst_sync_d;
            rst_cnt_q     <= rst_cnt_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            clock_en_q    <= clock_en_d;
            cycle_count_q <= cycle_count_d;
            div_cnt_q     <= div_cnt_d;
            mode_prev_q   <= mode_prev_d;
            step_sync_q   <= step_sync_d;
            db_cnt_q      <= db_cnt_d;
            db_level_q    <= db_level_d;
`ifdef K12A_CLOCK_CTRL_BREAK_EN
            halted_q      <= halted_d;
`endif
        end
    end

    assign cpu_reset_n = cpu_reset_n_q;
    assign clock_en    = clock_en_q;
    assign cycle_count = cycle_count_q;
    assign running     = (state_q == ST_ACTIVE) && ((mode == MODE_FREE) || (mode == MODE_DIV));
`ifdef K12A_CLOCK_CTRL_BREAK_EN
    assign halted      = halted_q;
`endif

endmodule

// File: tb/tb_k12a_clock_ctrl.sv
// Bench for k12a_clock_ctrl: directed and randomized mode sequences checked
// against a pulse-schedule model derived from the mode rules.
module tb_k12a_clock_ctrl;

    localparam int unsigned RST = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned DEB = 8;
    localparam int unsigned CW  = 32;

    logic          sys_clock = 1'b0;
    logic          reset_n;
    logic [1:0]    mode;
    logic [DW-1:0] divisor;
    logic          step_button;
    logic          cpu_reset_n;
    logic          clock_en;
    logic          running;
    logic [CW-1:0] cycle_count;
`ifdef K12A_CLOCK_CTRL_BREAK_EN
    logic [15:0]   pc;
    logic [15:0]   break_addr;
    logic          break_valid;
    logic          halted;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count = '0;
    bit          exp_en = 1'b0;
    bit          exp_active = 1'b0;
    logic [31:0] base;

    k12a_clock_ctrl #(
        .RESET_CYCLES   (RST),
        .DIV_WIDTH      (DW),
        .DEBOUNCE_CYCLES(DEB),
        .COUNT_WIDTH    (CW)
    ) dut (
        .sys_clock  (sys_clock),
        .reset_n    (reset_n),
        .mode       (mode),
        .divisor    (divisor),
        .step_button(step_button),
`ifdef K12A_CLOCK_CTRL_BREAK_EN
        .pc         (pc),
        .break_addr (break_addr),
        .break_valid(break_valid),
        .halted     (halted),
`endif
        .cpu_reset_n(cpu_reset_n),
        .clock_en   (clock_en),
        .running    (running),
        .cycle_count(cycle_count)
    );

    always #5 sys_clock = ~sys_clock;

`ifdef K12A_CLOCK_CTRL_BREAK_EN
    // Simple core stand-in: program counter advances on enabled edges
    always @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) pc <= 16'h0000;
        else if (clock_en) pc <= pc + 16'h0001;
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clock);
        @(negedge sys_clock);
    endtask

    // One edge: the model counts the pulse of the previous cycle, then the
    // expected enable of this edge is compared along with count and running.
    task automatic edge_expect(input string tag, input bit en);
        tick;
        exp_count = exp_count + 32'(exp_en);
        exp_en    = en;
        chk({tag, "_en"},  32'(clock_en), 32'(en));
        chk({tag, "_cnt"}, cycle_count, exp_count);
        chk({tag, "_run"}, 32'(running), 32'(exp_active && (mode == 2'b01 || mode == 2'b11)));
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        #1;
        exp_count  = '0;
        exp_en     = 1'b0;
        exp_active = 1'b0;
        chk("async_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        chk("async_clock_en",    32'(clock_en),    32'd0);
        chk("async_count",       cycle_count,      32'd0);
        chk("async_running",     32'(running),     32'd0);
        tick;
        tick;
    endtask

    // Release at a negedge: cpu_reset_n must rise on exactly the RST+2'th edge
    task automatic release_stretch(input string tag);
        reset_n = 1'b1;
        for (int k = 1; k <= int'(RST) + 2; k++) begin
            exp_active = (k >= int'(RST) + 2);
            edge_expect(tag, 1'b0);
            chk({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'(k >= int'(RST) + 2));
        end
    endtask

    // Enter mode m freshly (via a pass through step mode) and check len edges
    task automatic run_seg(input logic [1:0] m, input int d, input int len);
        mode = 2'b10;
        edge_expect("pre", 1'b0);
        mode    = m;
        divisor = DW'(d);
        for (int k = 1; k <= len; k++) begin
            bit e;
            case (m)
                2'b01:   e = (k >= 2);
                2'b11:   e = (k >= 2) && (((k - 1) % (d + 1)) == 0);
                default: e = 1'b0;
            endcase
            edge_expect("seg", e);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        mode        = 2'b00;
        divisor     = '0;
        step_button = 1'b0;
`ifdef K12A_CLOCK_CTRL_BREAK_EN
        break_addr  = 16'h0010;
        break_valid = 1'b0;
`endif
        #2;
        @(negedge sys_clock);

        // Reset stretch with free-run already selected, then 100 pulses
        mode = 2'b01;
        apply_reset;
        release_stretch("rst");
        for (int k = 0; k < 101; k++) edge_expect("free", 1'b1);
        chk("free_count_100", cycle_count, 32'd100);

        // Divided mode, divisor 3, then divisor dropped to 0 mid-count
        run_seg(2'b11, 3, 6);
        divisor = '0;
        for (int k = 0; k < 5; k++) edge_expect("div_to0", 1'b1);

        // Random mode segments
        for (int s = 0; s < 10; s++) begin
            logic [1:0] m;
            case ($urandom_range(0, 2))
                0:       m = 2'b00;
                1:       m = 2'b01;
                default: m = 2'b11;
            endcase
            run_seg(m, int'($urandom_range(0, 6)), int'($urandom_range(6, 30)));
        end

        // Single step through a bouncing press
        mode = 2'b10;
        edge_expect("st_enter", 1'b0);
        edge_expect("st_enter", 1'b0);
        for (int g = 0; g < 5; g++) begin
            step_button = 1'b1;
            for (int k = 0; k < 3; k++) edge_expect("glitch_hi", 1'b0);
            step_button = 1'b0;
            for (int k = 0; k < 3; k++) edge_expect("glitch_lo", 1'b0);
        end
        base = exp_count;
        step_button = 1'b1;
        for (int k = 1; k <= 20; k++) edge_expect("step_hold", (k == int'(DEB) + 2));
        step_button = 1'b0;
        for (int k = 0; k < 20; k++) edge_expect("step_release", 1'b0);
        chk("step_plus1", cycle_count, base + 32'd1);

        // Press in halt mode is dropped
        mode = 2'b00;
        edge_expect("halt_enter", 1'b0);
        step_button = 1'b1;
        for (int k = 0; k < 20; k++) edge_expect("halt_press", 1'b0);
        step_button = 1'b0;
        for (int k = 0; k < 20; k++) edge_expect("halt_release", 1'b0);
        chk("halt_no_step", cycle_count, base + 32'd1);

        // Async reset mid-run at cycle_count 57
        mode = 2'b01;
        apply_reset;
        release_stretch("rst2");
        for (int i = 0; i < 200 && exp_count != 32'd57; i++) edge_expect("run57", 1'b1);
        chk("count_57", cycle_count, 32'd57);
        apply_reset;

`ifdef K12A_CLOCK_CTRL_BREAK_EN
        // Breakpoint halts free-run; one step resumes
        break_valid = 1'b1;
        release_stretch("rst3");
        for (int i = 0; i < 100 && halted !== 1'b1; i++) tick;
        chk("brk_halted", 32'(halted), 32'd1);
        chk("brk_clock_en", 32'(clock_en), 32'd0);
        chk("brk_pc", 32'(pc), 32'h11);
        for (int i = 0; i < 3; i++) tick;
        chk("brk_pc_hold", 32'(pc), 32'h11);
        chk("brk_en_hold", 32'(clock_en), 32'd0);
        step_button = 1'b1;
        for (int i = 0; i < 40 && halted !== 1'b0; i++) tick;
        chk("brk_cleared", 32'(halted), 32'd0);
        chk("brk_step_en", 32'(clock_en), 32'd1);
        step_button = 1'b0;
        for (int i = 0; i < 20; i++) tick;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
